// File: rtl/msx_port_pkg.sv
// msx_port_pkg: shared types and helpers for the MSX port-A mouse/joystick controller.
//   mouse_phase_t     : nibble phase of the MSX mouse read sequence
//   MOUSE_TIMEOUT_DEF : default strobe-idle timeout in clk_sys cycles
//   nibble_rev()      : bit-reverses a nibble for the pin ordering
package msx_port_pkg;

    typedef enum logic [1:0] {PH_XH, PH_XL, PH_YH, PH_YL} mouse_phase_t;

    localparam int MOUSE_TIMEOUT_DEF = 100000;

    function automatic logic [3:0] nibble_rev(input logic [3:0] n);
        return {n[0], n[1], n[2], n[3]};
    endfunction

endpackage

// File: rtl/msx_mouse_latch.sv
// msx_mouse_latch: per-axis mouse delta latch with optional sign inversion.
// Optional feature macro: MSX_MOUSE_ACCUM_EN (saturating accumulate instead of overwrite).
// Ports:
//   clk_sys  in  clock
//   reset_n  in  synchronous active-low reset
//   i_load   in  new delta valid (mouse_strobe)
//   i_clr    in  clear request after the axis has been fully read
//   i_delta  in  9-bit two's complement delta
//   o_lat    out 9-bit latched value
module msx_mouse_latch #(
    parameter bit INV = 1'b0
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic       i_clr,
    input  logic [8:0] i_delta,
    output logic [8:0] o_lat
);

    logic [8:0] r_lat;
    logic [8:0] w_next;

`ifdef MSX_MOUSE_ACCUM_EN
    // 10 bits hold any sum/difference of two 9-bit values without overflow
    logic signed [9:0] w_sum;
    assign w_sum  = INV ? $signed({r_lat[8], r_lat}) - $signed({i_delta[8], i_delta})
                        : $signed({r_lat[8], r_lat}) + $signed({i_delta[8], i_delta});
    assign w_next = w_sum > 10'sd255  ? 9'h0FF :
                    w_sum < -10'sd256 ? 9'h100 : w_sum[8:0];
`else
    assign w_next = INV ? 9'(-i_delta) : i_delta;
`endif

    // A fresh sample beats the end-of-read clear so motion is never lost
    always_ff @(posedge clk_sys) begin
        if (!reset_n) r_lat <= '0;
        else if (i_load) r_lat <= w_next;
        else if (i_clr) r_lat <= '0;
    end

    assign o_lat = r_lat;

endmodule

// File: rtl/msx_mouse_port_ctrl.sv
// msx_mouse_port_ctrl: MSX joystick port A shared between host joystick and mouse nibble protocol.
// Optional feature macro: MSX_MOUSE_ACCUM_EN (accumulate deltas between reads, see msx_mouse_latch).
// Ports:
//   clk_sys       in  system clock
//   reset_n       in  synchronous active-low reset
//   mouse_x/y     in  9-bit two's complement deltas
//   mouse_flags   in  bit0 left, bit1 right button (active-high)
//   mouse_strobe  in  one-cycle pulse, new mouse data valid
//   joy           in  host joystick, active-low
//   stra          in  port-A strobe from the PSG
//   port_dout     out pin levels, 0 = pull low, 1 = released
//   mouse_active  out port is in mouse mode
module msx_mouse_port_ctrl
    import msx_port_pkg::*;
#(
    parameter int TIMEOUT = MOUSE_TIMEOUT_DEF,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [7:0] mouse_flags,
    input  logic       mouse_strobe,
    input  logic [5:0] joy,
    input  logic       stra,
    output logic [5:0] port_dout,
    output logic       mouse_active
);

    logic            r_stra_s, r_stra_d, r_active;
    mouse_phase_t    r_ph;
    logic [TO_W-1:0] r_cnt;
    logic [5:0]      r_dout;
    logic [8:0]      w_x_lat, w_y_lat, w_axis;
    logic [3:0]      w_nib;
    logic            w_tog, w_act_n, w_step, w_clr;
    logic            w_unused;

    // stra is sampled once before edge detection, so a toggle acts one edge after it is seen
    assign w_tog   = r_stra_s ^ r_stra_d;
    assign w_act_n = mouse_strobe | (r_active & (joy == 6'h3F));
    assign w_step  = r_active & w_act_n & w_tog;
    assign w_clr   = w_step & (r_ph == PH_YL);
    assign w_axis  = r_ph[1] ? w_y_lat : w_x_lat;
    assign w_nib   = r_ph[0] ? w_axis[4:1] : w_axis[8:5];
    assign w_unused = ^{w_x_lat[0], w_y_lat[0], mouse_flags[7:2]};

    msx_mouse_latch #(.INV(1'b1)) u_lat_x (
        .clk_sys(clk_sys), .reset_n(reset_n), .i_load(mouse_strobe),
        .i_clr(w_clr), .i_delta(mouse_x), .o_lat(w_x_lat)
    );

    msx_mouse_latch #(.INV(1'b0)) u_lat_y (
        .clk_sys(clk_sys), .reset_n(reset_n), .i_load(mouse_strobe),
        .i_clr(w_clr), .i_delta(mouse_y), .o_lat(w_y_lat)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_stra_s <= 1'b0;
            r_stra_d <= 1'b0;
            r_active <= 1'b0;
            r_ph     <= PH_XH;
            r_cnt    <= '0;
            r_dout   <= 6'h3F;
        end else begin
            r_stra_s <= stra;
            r_stra_d <= r_stra_s;
            r_active <= w_act_n;
            if (!w_act_n) begin
                r_ph   <= PH_XH;
                r_cnt  <= '0;
                r_dout <= joy | {6{stra}};
            end else begin
                r_dout[5:4] <= ~mouse_flags[1:0];
                if (w_step) begin
                    r_ph        <= mouse_phase_t'(r_ph + 2'd1);
                    r_cnt       <= TO_W'(TIMEOUT);
                    r_dout[3:0] <= nibble_rev(w_nib);
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == TO_W'(1)) r_ph <= PH_XH;
                end
            end
        end
    end

    assign port_dout    = r_dout;
    assign mouse_active = r_active;

endmodule
